div: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage, serving MIPS DIV and DIVU. It takes a start handshake from EX and computes one quotient bit per cycle. It holds the result until EX drops start. While the divider is busy, EX raises its stall request, which freezes the IF/ID/EX pipeline registers upstream. The divider is the EX-side agent that causes the stalls those registers honour.

---
 rtl/div.sv | 107 ++++++++++
 tb/tb_div.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per clock and holds the result until start_i drops.
// Result layout is {remainder, quotient}.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  // Layout: [64:33] partial remainder, [31:0] accumulated quotient bits,
  // with the unconsumed dividend bits shifting up through the middle.
  logic [64:0] work;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [32:0] trial;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes (two's-complement magnitude only for signed ops).
  assign op1_mag = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

  // Restoring trial subtraction; bit 32 set means the divisor did not fit.
  assign trial = {1'b0, work[63:32]} - {1'b0, dvsr};

  assign q_mag = work[31:0];
  assign r_mag = work[64:33];
  assign q_fix = neg_q ? (32'd0 - q_mag) : q_mag;
  assign r_fix = neg_r ? (32'd0 - r_mag) : r_mag;

  // Control FSM plus datapath; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      dvsr     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              cnt   <= 6'd0;
              work  <= {32'd0, op1_mag, 1'b0};
              dvsr  <= op2_mag;
              neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_r <= signed_div_i && opdata1_i[31];
            end
          end
        end
        BYZERO: begin
          // Division by zero is a defined zero result, not a trap.
          state    <= END;
          result_o <= 64'd0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt != 6'd32) begin
            if (trial[32]) work <= {work[63:0], 1'b0};
            else           work <= {trial[31:0], work[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            state    <= END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk  = 0;
  int n_pass = 0;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    int ia, ib;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      ia = a; ib = b;
      sa = ia; sb = ib;
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Full operation: start, wait for ready with a bound, check, hold, release.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int lat, exp_lat;
    exp     = model(s, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk);
    #1;
    // Operands are don't-care once sampled.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
    lat = 0;
    while (!ready_o && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("lat %h/%h", a, b), 64'(lat), 64'(exp_lat));
    chk($sformatf("res s=%0d %h/%h", s, a, b), result_o, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_rdy", 64'(ready_o), 64'd1);
      chk("hold_res", result_o, exp);
    end
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk("clr_rdy", 64'(ready_o), 64'd0);
    chk("clr_res", result_o, 64'd0);
  endtask

  // Raise start and return just after edge E(n).
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk);
    repeat (n) @(posedge clk);
  endtask

  // Watch for 40 cycles that ready never rises.
  task automatic quiet(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    #23;
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 5);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1);
    run_div(1'b0, 32'h12345678, 32'd0, 2);
    run_div(1'b1, 32'h80000000, 32'd0, 0);

    // Annul after E10
    launch(1'b0, 32'd1000, 32'd3, 10);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul10_rdy", 64'(ready_o), 64'd0);
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    quiet("annul10_quiet");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);

    // Annul on the final (cnt = 32) edge
    launch(1'b0, 32'd1000, 32'd3, 32);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul32_rdy", 64'(ready_o), 64'd0);
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    quiet("annul32_quiet");

    // Start together with annul in FREE is refused
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
    quiet("start_annul_quiet");

    // Reset mid-operation after E20
    launch(1'b0, 32'd77, 32'd5, 20);
    #2; rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    run_div(1'b0, 32'd9, 32'd3, 0);

    // Reset while holding a result clears outputs without a clock edge
    launch(1'b0, 32'd77, 32'd5, 33);
    #2;
    chk("pre_rst_rdy", 64'(ready_o), 64'd1);
    chk("pre_rst_res", result_o, model(1'b0, 32'd77, 32'd5));
    rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Back-to-back: run_div leaves start low for exactly one cycle
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 0);
    run_div(1'b0, 32'hDEADBEEF, 32'h00001234, 0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      bit s;
      logic [31:0] a, b;
      int sel;
      s   = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = $urandom_range(1, 16);
      else if (sel == 4) b = 32'hFFFFFFFF;
      else               b = $urandom;
      if (sel == 5) a = 32'h80000000;
      run_div(s, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
